// File: rtl/pll_lock_seq.sv
// PLL lock sequencer: qualifies PLL lock, pulses the steady-lock detector clear,
// holds the domain reset for a while after steady lock, then releases it and shows READY.
// Latency: 2-flop input sync plus 1 FSM edge; outputs are Moore decodes of state.
// Backpressure: none. This is a free-running control FSM with no handshake.
//
// Ports:
//   CLK, RST                - single clock; synchronous active-high reset
//   USR_PLL_LOCKED          - PLL lock flag (async, synchronized internally)
//   USR_PLL_LOCKED_STDY     - PLL steady-lock flag (async, synchronized internally)
//   USR_RSTN                - user reset, active-low (async, synchronized internally)
//   USR_LOCKED_STDY_RST     - steady-lock detector clear, high only in CLR_STDY
//   RSTN_OUT, READY         - sequenced domain reset release / ready, high only in RUN
//   LOSS_CNT                - saturating count of lock losses seen while in RUN
//   STATE                   - current FSM state encoding
module pll_lock_seq #(
    parameter int LOCK_WAIT    = 16,
    parameter int STDY_RST_LEN = 2,
    parameter int RST_HOLD     = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       USR_PLL_LOCKED,
    input  logic       USR_PLL_LOCKED_STDY,
    input  logic       USR_RSTN,
    output logic       USR_LOCKED_STDY_RST,
    output logic       RSTN_OUT,
    output logic       READY,
    output logic [7:0] LOSS_CNT,
    output logic [2:0] STATE
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] CLR_STDY  = 3'd2;
    localparam logic [2:0] WAIT_STDY = 3'd3;
    localparam logic [2:0] HOLD      = 3'd4;
    localparam logic [2:0] RUN       = 3'd5;

    // Terminal counts, widened by one bit so that the incremented counter
    // never wraps before the compare.
    localparam logic [16:0] LOCK_WAIT_C = 17'(LOCK_WAIT);
    localparam logic [8:0]  STDY_LEN_C  = 9'(STDY_RST_LEN);
    localparam logic [8:0]  HOLD_LEN_C  = 9'(RST_HOLD);

    // Two-flop synchronizers for the asynchronous inputs.
    logic [1:0] lock_sync;
    logic [1:0] stdy_sync;
    logic [1:0] urst_sync;
    logic       lock_s;
    logic       stdy_s;
    logic       urst_s;

    always_ff @(posedge CLK) begin
        if (RST) begin
            lock_sync <= 2'b00;
            stdy_sync <= 2'b00;
            urst_sync <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], USR_PLL_LOCKED};
            stdy_sync <= {stdy_sync[0], USR_PLL_LOCKED_STDY};
            urst_sync <= {urst_sync[0], USR_RSTN};
        end
    end

    assign lock_s = lock_sync[1];
    assign stdy_s = stdy_sync[1];
    assign urst_s = urst_sync[1];

    // FSM state and counters. wait_cnt counts consecutive locked edges in
    // WAIT_LOCK; phase_cnt times both the CLR_STDY pulse and the HOLD period.
    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_nxt;
    logic [7:0]  phase_cnt;
    logic [7:0]  phase_cnt_nxt;
    logic [7:0]  loss_cnt;
    logic [7:0]  loss_cnt_nxt;
    logic [16:0] wait_inc;
    logic [8:0]  phase_inc;
    logic        lost;

    assign wait_inc  = {1'b0, wait_cnt} + 17'd1;
    assign phase_inc = {1'b0, phase_cnt} + 9'd1;
    assign lost      = !lock_s || !stdy_s;

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        phase_cnt_nxt = phase_cnt;
        loss_cnt_nxt  = loss_cnt;

        case (state)
            IDLE: begin
                if (urst_s) begin
                    state_nxt    = WAIT_LOCK;
                    wait_cnt_nxt = 16'd0;
                end
            end
            WAIT_LOCK: begin
                if (!lock_s) begin
                    wait_cnt_nxt = 16'd0;
                end else if (wait_inc == LOCK_WAIT_C) begin
                    state_nxt     = CLR_STDY;
                    phase_cnt_nxt = 8'd0;
                end else begin
                    wait_cnt_nxt = wait_inc[15:0];
                end
            end
            CLR_STDY: begin
                if (!lock_s) begin
                    state_nxt    = WAIT_LOCK;
                    wait_cnt_nxt = 16'd0;
                end else if (phase_inc == STDY_LEN_C) begin
                    state_nxt     = WAIT_STDY;
                    phase_cnt_nxt = 8'd0;
                end else begin
                    phase_cnt_nxt = phase_inc[7:0];
                end
            end
            WAIT_STDY: begin
                // Lock loss wins over a simultaneous steady indication.
                if (!lock_s) begin
                    state_nxt    = WAIT_LOCK;
                    wait_cnt_nxt = 16'd0;
                end else if (stdy_s) begin
                    state_nxt     = HOLD;
                    phase_cnt_nxt = 8'd0;
                end
            end
            HOLD: begin
                if (lost) begin
                    state_nxt    = WAIT_LOCK;
                    wait_cnt_nxt = 16'd0;
                end else if (phase_inc == HOLD_LEN_C) begin
                    state_nxt = RUN;
                end else begin
                    phase_cnt_nxt = phase_inc[7:0];
                end
            end
            RUN: begin
                if (lost) begin
                    state_nxt    = WAIT_LOCK;
                    wait_cnt_nxt = 16'd0;
                    if (loss_cnt != 8'hFF) begin
                        loss_cnt_nxt = loss_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // User reset overrides everything and leaves the loss history intact.
        if (!urst_s) begin
            state_nxt    = IDLE;
            loss_cnt_nxt = loss_cnt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            wait_cnt  <= 16'd0;
            phase_cnt <= 8'd0;
            loss_cnt  <= 8'd0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            phase_cnt <= phase_cnt_nxt;
            loss_cnt  <= loss_cnt_nxt;
        end
    end

    assign USR_LOCKED_STDY_RST = (state == CLR_STDY);
    assign RSTN_OUT            = (state == RUN);
    assign READY               = (state == RUN);
    assign LOSS_CNT            = loss_cnt;
    assign STATE               = state;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with default parameters.
// Table of {inputs, edge count, expected outputs} records plus a lock-loss saturation loop.
// Outputs are sampled 1 time unit after the rising edge.
module tb_pll_lock_seq;

    logic       clk;
    logic       rst;
    logic       usr_pll_locked;
    logic       usr_pll_locked_stdy;
    logic       usr_rstn;
    logic       usr_locked_stdy_rst;
    logic       rstn_out;
    logic       ready;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    pll_lock_seq dut (
        .CLK                 (clk),
        .RST                 (rst),
        .USR_PLL_LOCKED      (usr_pll_locked),
        .USR_PLL_LOCKED_STDY (usr_pll_locked_stdy),
        .USR_RSTN            (usr_rstn),
        .USR_LOCKED_STDY_RST (usr_locked_stdy_rst),
        .RSTN_OUT            (rstn_out),
        .READY               (ready),
        .LOSS_CNT            (loss_cnt),
        .STATE               (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       lk;
        logic       sd;
        logic       ur;
        int         n;
        logic [2:0] st;
        logic [7:0] lc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic lk, input logic sd, input logic ur,
                       input int n, input logic [2:0] st, input logic [7:0] lc);
        vec_t v;
        v.rst = r; v.lk = lk; v.sd = sd; v.ur = ur; v.n = n; v.st = st; v.lc = lc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [7:0] lc);
        chk({tag, " STATE"}, int'(state), int'(st));
        chk({tag, " RSTN_OUT"}, int'(rstn_out), (st == 3'd5) ? 1 : 0);
        chk({tag, " READY"}, int'(ready), (st == 3'd5) ? 1 : 0);
        chk({tag, " STDY_RST"}, int'(usr_locked_stdy_rst), (st == 3'd2) ? 1 : 0);
        chk({tag, " LOSS_CNT"}, int'(loss_cnt), int'(lc));
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int exp_loss;
        bit ok;

        // ---- reset and power-up sequence: STATE=1 after edge 3, clear pulse
        //      after edges 19-20, RUN after edge 26
        add(1, 1, 1, 1, 2, 3'd0, 8'd0);
        add(0, 1, 1, 1, 2, 3'd0, 8'd0);
        add(0, 1, 1, 1, 1, 3'd1, 8'd0);
        add(0, 1, 1, 1, 15, 3'd1, 8'd0);
        add(0, 1, 1, 1, 1, 3'd2, 8'd0);
        add(0, 1, 1, 1, 1, 3'd2, 8'd0);
        add(0, 1, 1, 1, 1, 3'd3, 8'd0);
        add(0, 1, 1, 1, 1, 3'd4, 8'd0);
        add(0, 1, 1, 1, 3, 3'd4, 8'd0);
        add(0, 1, 1, 1, 1, 3'd5, 8'd0);
        // ---- steady flag lost in RUN: exit 3 edges later, count 1, then re-run
        add(0, 1, 0, 1, 2, 3'd5, 8'd0);
        add(0, 1, 0, 1, 1, 3'd1, 8'd1);
        add(0, 1, 1, 1, 15, 3'd1, 8'd1);
        add(0, 1, 1, 1, 1, 3'd2, 8'd1);
        add(0, 1, 1, 1, 2, 3'd3, 8'd1);
        add(0, 1, 1, 1, 1, 3'd4, 8'd1);
        add(0, 1, 1, 1, 4, 3'd5, 8'd1);
        // ---- one-cycle lock glitch in RUN, then a glitch at WAIT_LOCK cycle 10
        add(0, 0, 1, 1, 1, 3'd5, 8'd1);
        add(0, 1, 1, 1, 1, 3'd5, 8'd1);
        add(0, 1, 1, 1, 1, 3'd1, 8'd2);
        add(0, 1, 1, 1, 9, 3'd1, 8'd2);
        add(0, 0, 1, 1, 1, 3'd1, 8'd2);
        add(0, 1, 1, 1, 2, 3'd1, 8'd2);
        add(0, 1, 1, 1, 15, 3'd1, 8'd2);
        add(0, 1, 1, 1, 1, 3'd2, 8'd2);
        add(0, 1, 1, 1, 2, 3'd3, 8'd2);
        add(0, 1, 1, 1, 1, 3'd4, 8'd2);
        add(0, 1, 1, 1, 4, 3'd5, 8'd2);
        // ---- user reset in RUN, then in HOLD; loss count untouched
        add(0, 1, 1, 0, 2, 3'd5, 8'd2);
        add(0, 1, 1, 0, 1, 3'd0, 8'd2);
        add(0, 1, 1, 1, 2, 3'd0, 8'd2);
        add(0, 1, 1, 1, 1, 3'd1, 8'd2);
        add(0, 1, 1, 1, 16, 3'd2, 8'd2);
        add(0, 1, 1, 1, 2, 3'd3, 8'd2);
        add(0, 1, 1, 1, 1, 3'd4, 8'd2);
        add(0, 1, 1, 0, 2, 3'd4, 8'd2);
        add(0, 1, 1, 0, 1, 3'd0, 8'd2);
        // ---- RST pulse while in CLR_STDY
        add(0, 1, 1, 1, 2, 3'd0, 8'd2);
        add(0, 1, 1, 1, 1, 3'd1, 8'd2);
        add(0, 1, 1, 1, 16, 3'd2, 8'd2);
        add(1, 1, 1, 1, 1, 3'd0, 8'd0);
        add(0, 1, 1, 1, 2, 3'd0, 8'd0);
        add(0, 1, 1, 1, 1, 3'd1, 8'd0);
        // ---- lock lost on the first CLR_STDY edge aborts back to WAIT_LOCK
        add(0, 1, 1, 1, 14, 3'd1, 8'd0);
        add(0, 0, 1, 1, 1, 3'd1, 8'd0);
        add(0, 1, 1, 1, 1, 3'd2, 8'd0);
        add(0, 1, 1, 1, 1, 3'd1, 8'd0);
        add(0, 1, 1, 1, 15, 3'd1, 8'd0);
        add(0, 1, 1, 1, 1, 3'd2, 8'd0);
        // ---- WAIT_STDY parks while the steady flag is low
        add(0, 1, 0, 1, 2, 3'd3, 8'd0);
        add(0, 1, 0, 1, 5, 3'd3, 8'd0);
        add(0, 1, 1, 1, 2, 3'd3, 8'd0);
        add(0, 1, 1, 1, 1, 3'd4, 8'd0);
        add(0, 1, 1, 1, 4, 3'd5, 8'd0);

        rst                 = 1'b1;
        usr_pll_locked      = 1'b1;
        usr_pll_locked_stdy = 1'b1;
        usr_rstn            = 1'b1;

        foreach (tbl[i]) begin
            rst                 = tbl[i].rst;
            usr_pll_locked      = tbl[i].lk;
            usr_pll_locked_stdy = tbl[i].sd;
            usr_rstn            = tbl[i].ur;
            tick(tbl[i].n);
            check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].lc);
        end

        // ---- 300 lock losses from RUN: count saturates at 255
        exp_loss = 0;
        for (int i = 0; i < 300; i++) begin
            usr_pll_locked_stdy = 1'b0;
            ok = 1'b0;
            for (int k = 0; k < 10 && !ok; k++) begin
                tick(1);
                if (state == 3'd1) ok = 1'b1;
            end
            if (exp_loss < 255) exp_loss++;
            chk($sformatf("loss%0d exit", i), int'(ok), 1);
            chk($sformatf("loss%0d LOSS_CNT", i), int'(loss_cnt), exp_loss);
            usr_pll_locked_stdy = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 60 && !ok; k++) begin
                tick(1);
                if (state == 3'd5) ok = 1'b1;
            end
            chk($sformatf("loss%0d rerun", i), int'(ok), 1);
            if (!ok) break;
        end
        chk("final LOSS_CNT", int'(loss_cnt), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_seq.md
PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 SHALL have parameter LOCK_WAIT, default 16: consecutive locked cycles required before lock is accepted; legal range 1..65535.
REQ-002 SHALL have parameter STDY_RST_LEN, default 2: width in cycles of the steady-lock reset pulse; legal range 1..255.
REQ-003 SHALL have parameter RST_HOLD, default 4: cycles RSTN_OUT stays low after steady lock; legal range 1..255.
REQ-004 SHALL have port CLK, input, 1 bit: single clock for all state.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port USR_PLL_LOCKED, input, 1 bit: PLL lock flag, asynchronous to CLK.
REQ-007 SHALL have port USR_PLL_LOCKED_STDY, input, 1 bit: PLL steady-lock flag, asynchronous to CLK.
REQ-008 SHALL have port USR_RSTN, input, 1 bit: user reset, active-low, asynchronous to CLK.
REQ-009 SHALL have port USR_LOCKED_STDY_RST, output, 1 bit: steady-lock detector clear, fed back to the PLL.
REQ-010 SHALL have port RSTN_OUT, output, 1 bit: sequenced domain reset, active-low.
REQ-011 SHALL have port READY, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port LOSS_CNT, output, 8 bits: count of lock-loss events.
REQ-013 SHALL have port STATE, output, 3 bits: current FSM state encoding.

Function
REQ-014 SHALL pass USR_PLL_LOCKED, USR_PLL_LOCKED_STDY and USR_RSTN each through a 2-flop synchronizer; the FSM SHALL use only the synchronized copies (lock_s, stdy_s, urst_s).
REQ-015 SHALL implement FSM states with STATE encodings IDLE=0, WAIT_LOCK=1, CLR_STDY=2, WAIT_STDY=3, HOLD=4, RUN=5; values 6 and 7 SHALL go to IDLE on the next edge.
REQ-016 SHALL move IDLE->WAIT_LOCK on the first edge that samples urst_s=1, and SHALL clear the 16-bit wait counter on that move.
REQ-017 In WAIT_LOCK, SHALL increment the wait counter on each edge that samples lock_s=1, and SHALL clear it on each edge that samples lock_s=0.
REQ-018 SHALL move WAIT_LOCK->CLR_STDY on the edge where the counter would reach LOCK_WAIT.
REQ-019 SHALL hold USR_LOCKED_STDY_RST=1 for exactly STDY_RST_LEN cycles while in CLR_STDY, then move to WAIT_STDY.
REQ-020 In CLR_STDY, SHALL return to WAIT_LOCK if lock_s=0.
REQ-021 In WAIT_STDY, SHALL move to HOLD when stdy_s=1, and SHALL move to WAIT_LOCK when lock_s=0; lock_s=0 takes priority.
REQ-022 In HOLD, SHALL stay RST_HOLD cycles then move to RUN, and SHALL return to WAIT_LOCK if stdy_s=0 or lock_s=0.
REQ-023 In RUN, SHALL move to WAIT_LOCK on an edge sampling stdy_s=0 or lock_s=0, and SHALL increment LOSS_CNT on that same edge.
REQ-024 LOSS_CNT SHALL saturate at 255, SHALL count only RUN exits caused by lock loss, and SHALL be cleared only by RST.
REQ-025 urst_s=0 sampled in any state SHALL force IDLE on that edge; this has priority over all other transitions and SHALL NOT change LOSS_CNT.
REQ-026 All outputs SHALL be Moore decodes of registered state: RSTN_OUT=1 and READY=1 only in RUN; USR_LOCKED_STDY_RST=1 only in CLR_STDY.

Reset
REQ-027 On an edge with RST=1, SHALL set state IDLE, all counters 0, all synchronizer flops 0, LOSS_CNT=0, RSTN_OUT=0, READY=0, USR_LOCKED_STDY_RST=0, STATE=0.
REQ-028 RST asserted mid-sequence, including in RUN or CLR_STDY, SHALL take effect on the next edge, overriding every transition.

Verification
REQ-029 Defaults; all three inputs held at 1 from RST release -> STATE=1 after edge 3; USR_LOCKED_STDY_RST high after edges 19-20; RSTN_OUT and READY first high after edge 26.
REQ-030 Defaults; USR_PLL_LOCKED drops for 1 cycle at cycle 10 of WAIT_LOCK -> wait counter restarts from 0; CLR_STDY is entered 16 locked edges after recovery.
REQ-031 In RUN, USR_PLL_LOCKED_STDY driven 0 -> RSTN_OUT low 3 edges later, STATE=1, LOSS_CNT 0->1; restoring the input repeats the full sequence.
REQ-032 Force 300 RUN lock losses -> LOSS_CNT stops at 255 with no wrap to 0.
REQ-033 USR_RSTN driven 0 in HOLD and in RUN -> STATE=0 after 3 edges, RSTN_OUT=0, LOSS_CNT unchanged.
REQ-034 RST pulsed for 1 cycle in CLR_STDY -> USR_LOCKED_STDY_RST=0 and STATE=0 on the next edge, and LOSS_CNT=0.
